// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI register-access master.
// Frame layout helper used by the controller to build the 16-bit word.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        XFER,
        HOLD,
        GAP
    } state_e;

    localparam int   FRAME_BITS = 16;
    localparam int   EDGE_COUNT = 2 * FRAME_BITS;
    localparam logic RW_WRITE   = 1'b1;

    // Command byte {rw, addr}, then data; reads send a zero data byte.
    function automatic logic [FRAME_BITS-1:0] build_frame(
        input logic       rw,
        input logic [6:0] addr,
        input logic [7:0] wdata
    );
        return {rw, addr, (rw == RW_WRITE) ? wdata : 8'h00};
    endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK timing: clock divider, edge counter and the SCLK register.
// Leading/trailing flags mark the tick cycle of each SCLK edge.
module spi_sclk_gen
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic run_i,
    input  logic xfer_i,
    input  logic idle_lvl_i,
    output logic tick_o,
    output logic lead_o,
    output logic trail_o,
    output logic last_o,
    output logic sclk_o
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int EW = $clog2(EDGE_COUNT);
    localparam logic [DW-1:0] DIV_MAX  = DW'(CLK_DIV - 1);
    localparam logic [EW-1:0] EDGE_MAX = EW'(EDGE_COUNT - 1);

    logic [DW-1:0] div_q, div_d;
    logic [EW-1:0] edge_q, edge_d;
    logic          sclk_q, sclk_d;

    assign tick_o  = run_i && (div_q == DIV_MAX);
    assign lead_o  = xfer_i && tick_o && !edge_q[0];
    assign trail_o = xfer_i && tick_o && edge_q[0];
    assign last_o  = (edge_q == EDGE_MAX);
    assign sclk_o  = sclk_q;

    always_comb begin
        div_d  = div_q;
        edge_d = edge_q;
        sclk_d = sclk_q;
        if (clear_i) begin
            div_d  = '0;
            edge_d = '0;
        end else if (run_i) begin
            div_d = (div_q == DIV_MAX) ? '0 : div_q + 1'b1;
            if (xfer_i && tick_o) begin
                edge_d = edge_q + 1'b1;
            end
        end
        // Outside XFER the line rests at the (next) idle polarity.
        if (!xfer_i) begin
            sclk_d = idle_lvl_i;
        end else if (tick_o) begin
            sclk_d = ~sclk_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            div_q  <= '0;
            edge_q <= '0;
            sclk_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            edge_q <= edge_d;
            sclk_q <= sclk_d;
        end
    end

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI initiator: one 16-bit register read/write frame per start pulse.
// FSM, input latches, tx/rx shift registers and the read-data register.
module spi_master_ctrl
    import spi_pkg::*;
#(
    parameter int CLK_DIV    = 4,
    parameter int ADDR_WIDTH = 3,
    parameter int REG_WIDTH  = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic                  rw_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [REG_WIDTH-1:0]  wdata_i,
    input  logic [1:0]            mode_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [REG_WIDTH-1:0]  rdata_o,
    output logic                  spi_cs_n_o,
    output logic                  spi_clk_o,
    output logic                  spi_mosi_o,
    input  logic                  spi_miso_i
);

    state_e state_q, state_d;

    logic                  rw_q, rw_d;
    logic                  cpol_q, cpol_d;
    logic                  cpha_q, cpha_d;
    logic [FRAME_BITS-1:0] tx_q, tx_d;
    logic [REG_WIDTH-1:0]  rx_q, rx_d;
    logic [REG_WIDTH-1:0]  rdata_q, rdata_d;
    logic                  mosi_q, mosi_d;
    logic                  miso_q;

    logic accept;
    logic clear;
    logic tick;
    logic lead;
    logic trail;
    logic last_edge;
    logic sclk;
    logic frame_end;

    assign accept    = start_i && (state_q == IDLE);
    assign clear     = (state_d != state_q) || (state_q == IDLE);
    assign frame_end = (state_q == GAP) && tick;

    spi_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clear_i    (clear),
        .run_i      (state_q != IDLE),
        .xfer_i     (state_q == XFER),
        .idle_lvl_i (cpol_d),
        .tick_o     (tick),
        .lead_o     (lead),
        .trail_o    (trail),
        .last_o     (last_edge),
        .sclk_o     (sclk)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start_i) state_d = SETUP;
            SETUP:   if (tick) state_d = XFER;
            XFER:    if (tick && last_edge) state_d = HOLD;
            HOLD:    if (tick) state_d = GAP;
            GAP:     if (tick) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_o     = (state_q != IDLE);
        done_o     = frame_end;
        spi_cs_n_o = (state_q == IDLE) || (state_q == GAP);
        rdata_o    = rdata_q;
        if (frame_end && (rw_q != RW_WRITE)) begin
            rdata_o = rx_q;
        end
    end

    assign spi_clk_o  = sclk;
    assign spi_mosi_o = mosi_q;

    always_comb begin
        rw_d    = rw_q;
        cpol_d  = cpol_q;
        cpha_d  = cpha_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        mosi_d  = mosi_q;
        rdata_d = rdata_q;
        if (accept) begin
            rw_d   = rw_i;
            cpol_d = mode_i[1];
            cpha_d = mode_i[0];
            tx_d   = build_frame(rw_i, 7'(addr_i), 8'(wdata_i));
            mosi_d = mode_i[0] ? 1'b0 : tx_d[FRAME_BITS-1];
        end
        if (cpha_q) begin
            if (lead) begin
                mosi_d = tx_q[FRAME_BITS-1];
                tx_d   = {tx_q[FRAME_BITS-2:0], 1'b0};
            end
            if (trail) begin
                rx_d = {rx_q[REG_WIDTH-2:0], miso_q};
            end
        end else begin
            if (lead) begin
                rx_d = {rx_q[REG_WIDTH-2:0], miso_q};
            end
            // MSB already sits on MOSI, so the final trailing edge has no bit left.
            if (trail && !last_edge) begin
                mosi_d = tx_q[FRAME_BITS-2];
                tx_d   = {tx_q[FRAME_BITS-2:0], 1'b0};
            end
        end
        if (frame_end) begin
            mosi_d = 1'b0;
            if (rw_q != RW_WRITE) begin
                rdata_d = rx_q;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rw_q    <= 1'b0;
            cpol_q  <= 1'b0;
            cpha_q  <= 1'b0;
            tx_q    <= '0;
            rx_q    <= '0;
            rdata_q <= '0;
            mosi_q  <= 1'b0;
            miso_q  <= 1'b0;
        end else begin
            rw_q    <= rw_d;
            cpol_q  <= cpol_d;
            cpha_q  <= cpha_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            rdata_q <= rdata_d;
            mosi_q  <= mosi_d;
            miso_q  <= spi_miso_i;
        end
    end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: directed and random frames against a
// register-mapped peripheral model and an expected-register reference.
module tb_spi_master_ctrl;

    localparam int CLK_DIV = 4;
    localparam int BUSY_LEN = 35 * CLK_DIV;

    logic       clk = 1'b0;
    logic       rst_i;
    logic       start_i;
    logic       rw_i;
    logic [2:0] addr_i;
    logic [7:0] wdata_i;
    logic [1:0] mode_i;
    logic       busy_o;
    logic       done_o;
    logic [7:0] rdata_o;
    logic       spi_cs_n_o;
    logic       spi_clk_o;
    logic       spi_mosi_o;
    logic       spi_miso_i;

    int n_cmp = 0;
    int n_err = 0;

    spi_master_ctrl #(
        .CLK_DIV    (CLK_DIV),
        .ADDR_WIDTH (3),
        .REG_WIDTH  (8)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .start_i    (start_i),
        .rw_i       (rw_i),
        .addr_i     (addr_i),
        .wdata_i    (wdata_i),
        .mode_i     (mode_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .rdata_o    (rdata_o),
        .spi_cs_n_o (spi_cs_n_o),
        .spi_clk_o  (spi_clk_o),
        .spi_mosi_o (spi_mosi_o),
        .spi_miso_i (spi_miso_i)
    );

    always #5 clk = ~clk;

    // ---------------- peripheral model ----------------
    logic [7:0]  dev_cfg [8] = '{default: 8'h00};
    logic [1:0]  slv_mode = 2'b00;
    logic        prev_cs = 1'b1;
    logic        prev_sck = 1'b0;
    bit          in_frame = 0;
    int          slv_edges = 0;
    int          edge_err = 0;
    int          nin = 0;
    int          nout = 0;
    logic [15:0] sr = '0;
    logic [15:0] slv_word = '0;
    logic [7:0]  slv_junk = '0;
    logic [7:0]  slv_resp = '0;
    logic        is_wr = 1'b0;
    logic [2:0]  dev_addr = '0;
    logic        miso_drv = 1'b0;

    assign spi_miso_i = miso_drv;

    function automatic logic [7:0] dev_status(input logic [2:0] a);
        if (a == 3'd0) return 8'hCA;
        if (a == 3'd4) return dev_cfg[0][0] ? 8'hFF : 8'h00;
        return dev_cfg[a];
    endfunction

    function automatic logic out_bit(input int k);
        if (k < 8) return slv_junk[7-k];
        return slv_resp[15-k];
    endfunction

    always @(negedge clk) begin
        bit lead_e;
        if (rst_i) in_frame = 0;
        if (!spi_cs_n_o && prev_cs) begin
            in_frame  = 1;
            slv_edges = 0;
            nin       = 0;
            sr        = '0;
            slv_junk  = 8'($urandom);
            slv_resp  = '0;
            is_wr     = 1'b0;
            nout      = slv_mode[0] ? 0 : 1;
            if (!slv_mode[0]) miso_drv = out_bit(0);
        end else if (!spi_cs_n_o && in_frame && spi_clk_o !== prev_sck) begin
            slv_edges++;
            lead_e = (spi_clk_o !== slv_mode[1]);
            if (lead_e ^ slv_mode[0]) begin
                sr = {sr[14:0], spi_mosi_o};
                nin++;
                if (nin == 8) begin
                    is_wr    = sr[7];
                    dev_addr = sr[2:0];
                    slv_resp = is_wr ? 8'h00 : dev_status(sr[2:0]);
                end
            end else begin
                if (nout < 16) miso_drv = out_bit(nout);
                nout++;
            end
        end
        if (spi_cs_n_o && !prev_cs && in_frame) begin
            in_frame = 0;
            slv_word = sr;
            if (is_wr && nin == 16) dev_cfg[dev_addr] = sr[7:0];
        end
        if (spi_cs_n_o && prev_cs && spi_clk_o !== prev_sck) edge_err++;
        prev_cs  = spi_cs_n_o;
        prev_sck = spi_clk_o;
    end

    // ---------------- reference model ----------------
    logic [7:0] exp_cfg [8] = '{default: 8'h00};
    logic [7:0] rd_model = 8'h00;

    function automatic logic [7:0] exp_status(input logic [2:0] a);
        if (a == 3'd0) return 8'hCA;
        if (a == 3'd4) return exp_cfg[0][0] ? 8'hFF : 8'h00;
        return exp_cfg[a];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called right after a falling edge; leaves off at a falling edge.
    task automatic frame(input logic rw, input logic [2:0] a,
                         input logic [7:0] wd, input logic [1:0] md,
                         input bit extra, input int rst_edge);
        int          cyc;
        int          dones;
        bit          aborted;
        logic [7:0]  rd_done;
        logic [7:0]  exp_rd;
        logic [15:0] exp_word;
        exp_word = {rw, 4'b0000, a, rw ? wd : 8'h00};
        exp_rd   = rw ? rd_model : exp_status(a);
        slv_mode = md;
        rw_i     = rw;
        addr_i   = a;
        wdata_i  = wd;
        mode_i   = md;
        start_i  = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        chk("cs_fall", 32'(spi_cs_n_o), 0);
        chk("busy_rise", 32'(busy_o), 1);
        chk("sclk_idle_before", 32'(spi_clk_o), 32'(md[1]));
        cyc     = 0;
        dones   = 0;
        aborted = 0;
        rd_done = 8'hxx;
        while (busy_o === 1'b1 && cyc < 1000 && !aborted) begin
            cyc++;
            if (done_o === 1'b1) begin
                dones++;
                rd_done = rdata_o;
            end
            if (cyc == 5) begin
                rw_i    = 1'($urandom);
                addr_i  = 3'($urandom);
                wdata_i = 8'($urandom);
                mode_i  = 2'($urandom);
            end
            start_i = extra && (cyc == 10 || cyc == 50);
            if (rst_edge >= 0 && slv_edges == rst_edge) begin
                rst_i = 1'b1;
                #1;
                chk("rst_cs_n", 32'(spi_cs_n_o), 1);
                chk("rst_busy", 32'(busy_o), 0);
                chk("rst_done", 32'(done_o), 0);
                chk("rst_sclk", 32'(spi_clk_o), 0);
                chk("rst_rdata", 32'(rdata_o), 0);
                aborted = 1;
            end else begin
                @(negedge clk);
            end
        end
        start_i = 1'b0;
        if (aborted) begin
            @(negedge clk);
            rst_i = 1'b0;
            rd_model = 8'h00;
            chk("abort_no_done", 32'(dones), 0);
            @(negedge clk);
        end else begin
            chk("busy_len", 32'(cyc), 32'(BUSY_LEN));
            chk("done_cnt", 32'(dones), 1);
            chk("rdata_at_done", 32'(rd_done), 32'(exp_rd));
            chk("rdata_held", 32'(rdata_o), 32'(exp_rd));
            chk("sclk_idle_after", 32'(spi_clk_o), 32'(md[1]));
            chk("mosi_word", 32'(slv_word), 32'(exp_word));
            chk("sclk_edges", 32'(slv_edges), 32);
            if (rw) exp_cfg[a] = wd;
            rd_model = exp_rd;
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_i   = 1'b1;
        start_i = 1'b0;
        rw_i    = 1'b0;
        addr_i  = '0;
        wdata_i = '0;
        mode_i  = '0;
        repeat (3) @(negedge clk);
        chk("reset_cs_n", 32'(spi_cs_n_o), 1);
        chk("reset_sclk", 32'(spi_clk_o), 0);
        chk("reset_mosi", 32'(spi_mosi_o), 0);
        chk("reset_busy", 32'(busy_o), 0);
        chk("reset_done", 32'(done_o), 0);
        chk("reset_rdata", 32'(rdata_o), 0);
        rst_i = 1'b0;
        repeat (2) @(negedge clk);

        frame(1'b1, 3'd2, 8'hA5, 2'b00, 0, -1);
        frame(1'b0, 3'd0, 8'h00, 2'b11, 0, -1);
        frame(1'b1, 3'd1, 8'h5A, 2'b01, 0, -1);
        frame(1'b0, 3'd1, 8'h00, 2'b01, 0, -1);
        frame(1'b0, 3'd1, 8'h00, 2'b10, 0, -1);

        frame(1'b1, 3'd6, 8'h96, 2'b00, 1, -1);
        repeat (20) @(negedge clk);
        chk("no_queued_frame", 32'(busy_o), 0);

        frame(1'b1, 3'd3, 8'h77, 2'b00, 0, 9);
        frame(1'b1, 3'd3, 8'h3C, 2'b00, 0, -1);
        frame(1'b0, 3'd3, 8'h00, 2'b00, 0, -1);

        frame(1'b1, 3'd0, 8'h01, 2'b00, 0, -1);
        frame(1'b0, 3'd4, 8'h00, 2'b00, 0, -1);
        frame(1'b1, 3'd0, 8'h00, 2'b00, 0, -1);
        frame(1'b0, 3'd4, 8'h00, 2'b00, 0, -1);
        frame(1'b0, 3'd0, 8'h00, 2'b00, 0, -1);

        for (int i = 0; i < 24; i++) begin
            frame(1'($urandom), 3'($urandom), 8'($urandom),
                  2'($urandom), 0, -1);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 6)) @(negedge clk);
            end
        end

        chk("no_sclk_edge_cs_high", 32'(edge_err), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
